pm_ctrl: RTL and testbench

Program-memory responder for the program sequencer. Serves instruction fetches (`ps_pm_add`/`ps_pm_cslt`/`ps_pm_wrb` in, `pm_ps_op` out) and accepts sequencer-side PM writes. Boots its array from a 16-bit host loader after reset. Holds the core in stall (`pm_stallb` low) until the program is loaded.

---
 rtl/pm_pkg.sv | 20 ++
 rtl/pm_sram.sv | 25 ++
 rtl/pm_ctrl.sv | 166 ++++++++++++++++
 tb/tb_pm_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/pm_pkg.sv
// Shared definitions for the program-memory responder: FSM encoding and
// default array geometry / no-operation opcode.
package pm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD_LO = 2'd1,
        ST_LOAD_HI = 2'd2,
        ST_RUN     = 2'd3
    } pm_state_t;

    localparam int          PM_DEPTH_DEF = 256;
    localparam logic [31:0] PM_NOP_DEF   = 32'h0000_0000;

    // Address width of the array; a depth of one still needs a one-bit index.
    function automatic int pm_aw(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/pm_sram.sv
// Single-port synchronous-read instruction array. Contents are never reset.
module pm_sram
    import pm_pkg::*;
#(
    parameter int PM_DEPTH = PM_DEPTH_DEF,
    parameter int AW       = pm_aw(PM_DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdt,
    output logic [31:0]   rdt
);

    logic [31:0] mem [PM_DEPTH];

    // Write commits at the sampling edge; read data is registered one cycle later.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdt;
        end
        rdt <= mem[addr];
    end

endmodule

// File: rtl/pm_ctrl.sv
// Program-memory responder: boots the array from a 16-bit host loader, then
// serves sequencer fetches and writes with one-cycle registered read latency.
module pm_ctrl
    import pm_pkg::*;
#(
    parameter int          PM_DEPTH = PM_DEPTH_DEF,
    parameter logic [31:0] PM_NOP   = PM_NOP_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ps_pm_cslt,
    input  logic        ps_pm_wrb,
    input  logic [15:0] ps_pm_add,
    input  logic [31:0] ps_pm_wdt,
    output logic [31:0] pm_ps_op,
    output logic        pm_stallb,
    input  logic        hst_pm_start,
    input  logic [15:0] hst_pm_len,
    input  logic        hst_pm_vld,
    input  logic [15:0] hst_pm_dt,
    output logic        pm_hst_rdy,
    output logic        pm_boot_done,
    output logic        pm_err
);

    localparam int          AW      = pm_aw(PM_DEPTH);
    localparam logic [16:0] DEPTH17 = 17'(PM_DEPTH);

    pm_state_t   r_state;
    pm_state_t   w_state_nxt;
    logic        w_boot_done_nxt;
    logic [15:0] r_len;
    logic [15:0] r_lo;
    logic [16:0] r_cnt;
    logic        r_err;
    logic        r_boot_done;
    logic        r_rd_vld;
    logic [31:0] r_op_hold;
    logic [31:0] w_rdt;
    logic [31:0] w_op;

    // Start is honoured only outside a load; a start in RUN also suppresses that cycle's fetch.
    wire w_start_ok = hst_pm_start && ((r_state == ST_IDLE) || (r_state == ST_RUN));
    wire w_hi_acc   = (r_state == ST_LOAD_HI) && hst_pm_vld;
    wire w_last     = (r_cnt == ({1'b0, r_len} - 17'd1));
    wire w_cnt_ok   = (r_cnt < DEPTH17);
    wire w_add_ok   = ({1'b0, ps_pm_add} < DEPTH17);
    wire w_seq_act  = (r_state == ST_RUN) && !w_start_ok && ps_pm_cslt;
    wire w_seq_rd   = w_seq_act && ps_pm_wrb && w_add_ok;
    wire w_seq_we   = w_seq_act && !ps_pm_wrb && w_add_ok;
    wire w_ld_we    = w_hi_acc && w_cnt_ok;

    wire          w_we   = w_ld_we || w_seq_we;
    wire [AW-1:0] w_addr = (r_state == ST_LOAD_HI) ? r_cnt[AW-1:0] : ps_pm_add[AW-1:0];
    wire [31:0]   w_wdt  = (r_state == ST_LOAD_HI) ? {hst_pm_dt, r_lo} : ps_pm_wdt;

    pm_sram #(.PM_DEPTH(PM_DEPTH), .AW(AW)) u_sram (
        .clk  (clk),
        .we   (w_we),
        .addr (w_addr),
        .wdt  (w_wdt),
        .rdt  (w_rdt)
    );

    assign w_op         = r_rd_vld ? w_rdt : r_op_hold;
    assign pm_ps_op     = w_op;
    assign pm_stallb    = (r_state == ST_RUN);
    assign pm_hst_rdy   = (r_state == ST_LOAD_LO) || (r_state == ST_LOAD_HI);
    assign pm_boot_done = r_boot_done;
    assign pm_err       = r_err;

    // Boot FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and boot-complete pulse request.
    always_comb begin
        w_state_nxt     = r_state;
        w_boot_done_nxt = 1'b0;
        case (r_state)
            ST_IDLE, ST_RUN: begin
                if (w_start_ok) begin
                    if (hst_pm_len == 16'd0) begin
                        w_state_nxt     = ST_RUN;
                        w_boot_done_nxt = 1'b1;
                    end else begin
                        w_state_nxt = ST_LOAD_LO;
                    end
                end
            end
            ST_LOAD_LO: begin
                if (hst_pm_vld) begin
                    w_state_nxt = ST_LOAD_HI;
                end
            end
            ST_LOAD_HI: begin
                if (hst_pm_vld) begin
                    if (w_last) begin
                        w_state_nxt     = ST_RUN;
                        w_boot_done_nxt = 1'b1;
                    end else begin
                        w_state_nxt = ST_LOAD_LO;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Word counter, sticky error and boot-done pulse; overflowing words still advance the counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= 17'd0;
            r_err       <= 1'b0;
            r_boot_done <= 1'b0;
        end else begin
            r_boot_done <= w_boot_done_nxt;
            if (w_start_ok) begin
                r_cnt <= 17'd0;
                r_err <= 1'b0;
            end else begin
                if (w_hi_acc) begin
                    r_cnt <= r_cnt + 17'd1;
                end
                if ((w_hi_acc && !w_cnt_ok) || (w_seq_act && !w_add_ok)) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    // Boot length and pending low half-word; plain data, no reset needed.
    always_ff @(posedge clk) begin
        if (w_start_ok) begin
            r_len <= hst_pm_len;
        end
        if ((r_state == ST_LOAD_LO) && hst_pm_vld) begin
            r_lo <= hst_pm_dt;
        end
    end

    // Output selection: fresh array data after a read, NOP after write/error/non-RUN, else hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_vld  <= 1'b0;
            r_op_hold <= PM_NOP;
        end else begin
            r_rd_vld <= w_seq_rd;
            if (w_seq_act) begin
                if (!w_seq_rd) begin
                    r_op_hold <= PM_NOP;
                end
            end else if ((r_state == ST_RUN) && !w_start_ok) begin
                r_op_hold <= w_op;
            end else begin
                r_op_hold <= PM_NOP;
            end
        end
    end

endmodule

// File: tb/tb_pm_ctrl.sv
// Bench for pm_ctrl: directed boot/fetch scenarios plus randomized boot and
// sequencer traffic checked against a word-array model of the program memory.
module tb_pm_ctrl;

    localparam int          DEPTH = 256;
    localparam logic [31:0] NOP   = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        ps_pm_cslt;
    logic        ps_pm_wrb;
    logic [15:0] ps_pm_add;
    logic [31:0] ps_pm_wdt;
    logic [31:0] pm_ps_op;
    logic        pm_stallb;
    logic        hst_pm_start;
    logic [15:0] hst_pm_len;
    logic        hst_pm_vld;
    logic [15:0] hst_pm_dt;
    logic        pm_hst_rdy;
    logic        pm_boot_done;
    logic        pm_err;

    int errors = 0;
    int checks = 0;

    logic [31:0] mdl_mem [DEPTH];
    logic        mdl_err;
    logic [31:0] mdl_op;
    logic [31:0] bw [$];

    pm_ctrl #(.PM_DEPTH(DEPTH), .PM_NOP(NOP)) dut (
        .clk          (clk),
        .rst          (rst),
        .ps_pm_cslt   (ps_pm_cslt),
        .ps_pm_wrb    (ps_pm_wrb),
        .ps_pm_add    (ps_pm_add),
        .ps_pm_wdt    (ps_pm_wdt),
        .pm_ps_op     (pm_ps_op),
        .pm_stallb    (pm_stallb),
        .hst_pm_start (hst_pm_start),
        .hst_pm_len   (hst_pm_len),
        .hst_pm_vld   (hst_pm_vld),
        .hst_pm_dt    (hst_pm_dt),
        .pm_hst_rdy   (pm_hst_rdy),
        .pm_boot_done (pm_boot_done),
        .pm_err       (pm_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send_half(input logic [15:0] h, input int maxgap);
        int g;
        g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
        hst_pm_vld = 1'b0;
        repeat (g) step();
        chk("rdy_during_load", pm_hst_rdy, 1'b1);
        hst_pm_vld = 1'b1;
        hst_pm_dt  = h;
        step();
        hst_pm_vld = 1'b0;
    endtask

    // Boots the words in bw; the model stores those that fit, flags overflow.
    task automatic boot_run(input int maxgap);
        int n;
        n = bw.size();
        hst_pm_start = 1'b1;
        hst_pm_len   = 16'(n);
        step();
        hst_pm_start = 1'b0;
        mdl_err = 1'b0;
        for (int i = 0; i < n; i++) begin
            send_half(bw[i][15:0], maxgap);
            send_half(bw[i][31:16], maxgap);
            if (i < DEPTH) mdl_mem[i] = bw[i];
            else mdl_err = 1'b1;
            if (i < n - 1) begin
                chk("done_early", pm_boot_done, 1'b0);
                chk("stallb_load", pm_stallb, 1'b0);
            end
        end
        chk("boot_done", pm_boot_done, 1'b1);
        chk("stallb_run", pm_stallb, 1'b1);
        chk("rdy_run", pm_hst_rdy, 1'b0);
        chk("err_boot", pm_err, mdl_err);
    endtask

    task automatic rd(input logic [15:0] a, input logic [31:0] exp, input string tag);
        ps_pm_cslt = 1'b1;
        ps_pm_wrb  = 1'b1;
        ps_pm_add  = a;
        step();
        ps_pm_cslt = 1'b0;
        chk(tag, pm_ps_op, exp);
    endtask

    initial begin
        rst = 1'b1; ps_pm_cslt = 1'b0; ps_pm_wrb = 1'b1; ps_pm_add = '0; ps_pm_wdt = '0;
        hst_pm_start = 1'b0; hst_pm_len = '0; hst_pm_vld = 1'b0; hst_pm_dt = '0;
        step(); step();
        chk("rst_op", pm_ps_op, NOP);
        chk("rst_stallb", pm_stallb, 1'b0);
        chk("rst_rdy", pm_hst_rdy, 1'b0);
        chk("rst_done", pm_boot_done, 1'b0);
        chk("rst_err", pm_err, 1'b0);
        rst = 1'b0;
        step();
        chk("idle_stallb", pm_stallb, 1'b0);

        // Three-word boot and read-back.
        bw = '{32'h1111_2222, 32'h3333_4444, 32'h5555_6666};
        boot_run(0);
        step();
        chk("done_pulse_end", pm_boot_done, 1'b0);
        chk("op_after_boot", pm_ps_op, NOP);
        rd(16'd0, 32'h1111_2222, "rd0");
        rd(16'd1, 32'h3333_4444, "rd1");
        rd(16'd2, 32'h5555_6666, "rd2");

        // Write then read back.
        ps_pm_cslt = 1'b1; ps_pm_wrb = 1'b0; ps_pm_add = 16'd5; ps_pm_wdt = 32'hDEAD_BEEF;
        step();
        ps_pm_cslt = 1'b0; ps_pm_wrb = 1'b1;
        chk("op_after_wr", pm_ps_op, NOP);
        mdl_mem[5] = 32'hDEAD_BEEF;
        rd(16'd5, 32'hDEAD_BEEF, "rd_after_wr");

        // Out-of-range read.
        rd(16'h0100, NOP, "rd_oor");
        chk("err_oor", pm_err, 1'b1);
        rd(16'd1, 32'h3333_4444, "rd_after_oor");
        chk("err_sticky", pm_err, 1'b1);

        // Hold on deselect.
        rd(16'd2, 32'h5555_6666, "rd2_hold");
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold", pm_ps_op, 32'h5555_6666);
        end

        // Zero-length boot.
        hst_pm_start = 1'b1; hst_pm_len = 16'd0;
        step();
        hst_pm_start = 1'b0;
        chk("len0_done", pm_boot_done, 1'b1);
        chk("len0_stallb", pm_stallb, 1'b1);
        chk("len0_rdy", pm_hst_rdy, 1'b0);
        chk("len0_err_clr", pm_err, 1'b0);
        step();
        chk("len0_done_end", pm_boot_done, 1'b0);
        chk("len0_rdy2", pm_hst_rdy, 1'b0);

        // Randomized overflowing boot: two words beyond the array must be discarded.
        bw.delete();
        for (int i = 0; i < DEPTH + 2; i++) bw.push_back($urandom);
        boot_run(2);
        rd(16'd0, mdl_mem[0], "ovf_rd0");
        rd(16'(DEPTH - 1), mdl_mem[DEPTH - 1], "ovf_rd_top");
        rd(16'd1, mdl_mem[1], "ovf_rd1");

        // Clear the error, then random sequencer traffic against the model.
        hst_pm_start = 1'b1; hst_pm_len = 16'd0;
        step();
        hst_pm_start = 1'b0;
        mdl_err = 1'b0;
        mdl_op  = NOP;
        for (int i = 0; i < 300; i++) begin
            ps_pm_cslt = ($urandom_range(3, 0) != 0);
            ps_pm_wrb  = $urandom_range(1, 0) != 0;
            ps_pm_add  = ($urandom_range(9, 0) == 0) ? 16'($urandom_range(65535, DEPTH))
                                                      : 16'($urandom_range(DEPTH - 1, 0));
            ps_pm_wdt  = $urandom;
            if (ps_pm_cslt) begin
                if (int'(ps_pm_add) >= DEPTH) begin
                    mdl_op  = NOP;
                    mdl_err = 1'b1;
                end else if (ps_pm_wrb) begin
                    mdl_op = mdl_mem[ps_pm_add];
                end else begin
                    mdl_mem[ps_pm_add] = ps_pm_wdt;
                    mdl_op = NOP;
                end
            end
            step();
            chk("rand_op", pm_ps_op, mdl_op);
            chk("rand_err", pm_err, mdl_err);
        end
        ps_pm_cslt = 1'b0;

        // Reset in the middle of a boot, then reboot one word.
        hst_pm_start = 1'b1; hst_pm_len = 16'd3;
        step();
        hst_pm_start = 1'b0;
        send_half(16'hBBBB, 0);
        send_half(16'hCCCC, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_stallb", pm_stallb, 1'b0);
        chk("midrst_rdy", pm_hst_rdy, 1'b0);
        chk("midrst_op", pm_ps_op, NOP);
        chk("midrst_err", pm_err, 1'b0);
        step();
        chk("midrst_idle_rdy", pm_hst_rdy, 1'b0);
        bw = '{32'hAAAA_5555};
        boot_run(0);
        rd(16'd0, 32'hAAAA_5555, "reboot_rd0");
        rd(16'd1, mdl_mem[1], "reboot_rd1_kept");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
